// File: rtl/io_sequencer_pkg.sv
// Shared definitions for the IO sequencer: FSM states, stage_sel codes,
// transfer direction codes and the per-stage file table.
package io_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_IN,
        S_LOAD_PAR,
        S_CALC,
        S_STORE,
        S_FIN
    } state_t;

    typedef enum logic [1:0] {
        SEL_CONV1   = 2'd0,
        SEL_CONV2   = 2'd1,
        SEL_FC      = 2'd2,
        SEL_INVALID = 2'd3
    } stage_sel_t;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    typedef struct packed {
        logic [15:0] in_lo;
        logic [15:0] in_hi;
        logic [15:0] par_lo;
        logic [15:0] ppo;
        logic [15:0] n_out;
        logic [15:0] out_lo;
    } stage_row_t;

    localparam stage_row_t ROW_CONV1 = '{in_lo: 16'd0, in_hi: 16'd0, par_lo: 16'd1,
                                         ppo: 16'd1, n_out: 16'd32, out_lo: 16'd97};
    localparam stage_row_t ROW_CONV2 = '{in_lo: 16'd129, in_hi: 16'd160, par_lo: 16'd161,
                                         ppo: 16'd32, n_out: 16'd64, out_lo: 16'd2338};
    localparam stage_row_t ROW_FC    = '{in_lo: 16'd2402, in_hi: 16'd2405, par_lo: 16'd2406,
                                         ppo: 16'd40, n_out: 16'd1, out_lo: 16'd2447};

    // Parameter file index; worst case 63*32+31 plus base stays inside 16 bits.
    function automatic logic [15:0] par_file(input logic [15:0] par_lo, o, ppo, p);
        return par_lo + o * ppo + p;
    endfunction

endpackage

// File: rtl/io_sequencer_if.sv
// Handshake bundle between the sequencer, the IO stage and the compute engine.
interface io_sequencer_if;

    logic        io_req;
    logic [15:0] io_file;
    logic        io_rw;
    logic        io_done;
    logic        calc_start;
    logic        calc_done;

    modport master (output io_req, io_file, io_rw, calc_start,
                    input  io_done, calc_done);

    modport slave  (input  io_req, io_file, io_rw, calc_start,
                    output io_done, calc_done);

endinterface

// File: rtl/io_sequencer_stage_table.sv
// Combinational lookup from stage_sel to the six stage table fields.
module stage_table
    import io_sequencer_pkg::*;
(
    input  logic [1:0] stage_sel,
    output stage_row_t row,
    output logic       valid
);

    always_comb begin
        row   = '0;
        valid = 1'b1;
        case (stage_sel_t'(stage_sel))
            SEL_CONV1: row = ROW_CONV1;
            SEL_CONV2: row = ROW_CONV2;
            SEL_FC:    row = ROW_FC;
            default:   valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/io_sequencer.sv
// Stage sequencer: walks input, parameter and output file transfers around
// each compute pass for the selected network stage.
module io_sequencer
    import io_sequencer_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [1:0]     stage_sel,
    input  logic           abort,
    io_sequencer_if.master bus,
    output logic           busy,
    output logic           done,
    output logic           err
);

    state_t      r_state, w_next;
    stage_row_t  w_row;
    logic        w_sel_valid;
    logic [15:0] r_in_hi, r_par_lo, r_ppo, r_n_out, r_out_lo;
    logic [15:0] r_file, r_o, r_p;
    logic        r_gap, r_calc_entry, r_err;
    logic        w_ack, w_launch, w_last_in, w_last_par, w_last_out;

    stage_table u_stage_table (
        .stage_sel (stage_sel),
        .row       (w_row),
        .valid     (w_sel_valid)
    );

    assign w_ack      = bus.io_req & bus.io_done;
    assign w_launch   = (r_state == S_IDLE) & start & w_sel_valid & ~abort;
    assign w_last_in  = (r_file == r_in_hi);
    assign w_last_par = (r_p == r_ppo - 16'd1);
    assign w_last_out = (r_o == r_n_out - 16'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (abort) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:     if (w_launch) w_next = S_LOAD_IN;
                S_LOAD_IN:  if (w_ack && w_last_in) w_next = S_LOAD_PAR;
                S_LOAD_PAR: if (w_ack && w_last_par) w_next = S_CALC;
                S_CALC:     if (bus.calc_done) w_next = S_STORE;
                S_STORE:    if (w_ack) w_next = w_last_out ? S_FIN : S_LOAD_PAR;
                S_FIN:      w_next = S_IDLE;
                default:    w_next = S_IDLE;
            endcase
        end
    end

    // r_gap forces the mandatory idle cycle after every accepted io_done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_in_hi      <= '0;
            r_par_lo     <= '0;
            r_ppo        <= '0;
            r_n_out      <= '0;
            r_out_lo     <= '0;
            r_file       <= '0;
            r_o          <= '0;
            r_p          <= '0;
            r_gap        <= 1'b0;
            r_calc_entry <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_gap        <= w_ack;
            r_calc_entry <= (w_next == S_CALC) && (r_state != S_CALC);
            r_err        <= (r_state == S_IDLE) && start && !w_sel_valid && !abort;
            if (w_launch) begin
                r_in_hi  <= w_row.in_hi;
                r_par_lo <= w_row.par_lo;
                r_ppo    <= w_row.ppo;
                r_n_out  <= w_row.n_out;
                r_out_lo <= w_row.out_lo;
                r_file   <= w_row.in_lo;
                r_o      <= '0;
                r_p      <= '0;
            end else if (w_ack && !abort) begin
                case (r_state)
                    S_LOAD_IN: begin
                        r_file <= r_file + 16'd1;
                        if (w_last_in) r_p <= '0;
                    end
                    S_LOAD_PAR: r_p <= r_p + 16'd1;
                    S_STORE: begin
                        if (!w_last_out) begin
                            r_o <= r_o + 16'd1;
                            r_p <= '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        bus.io_req     = 1'b0;
        bus.io_rw      = RW_READ;
        bus.io_file    = '0;
        bus.calc_start = r_calc_entry;
        busy           = (r_state != S_IDLE);
        done           = (r_state == S_FIN);
        err            = r_err;
        case (r_state)
            S_LOAD_IN: begin
                bus.io_req  = !r_gap;
                bus.io_file = r_file;
            end
            S_LOAD_PAR: begin
                bus.io_req  = !r_gap;
                bus.io_file = par_file(r_par_lo, r_o, r_ppo, r_p);
            end
            S_STORE: begin
                bus.io_req  = !r_gap;
                bus.io_rw   = RW_WRITE;
                bus.io_file = r_out_lo + r_o;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_io_sequencer.sv
// Scoreboard bench for io_sequencer: expected file transfers, compute pulses
// and completion events are derived from the stage table and matched in order.
module tb_io_sequencer;

    localparam int EV_IO   = 0;
    localparam int EV_CALC = 1;
    localparam int EV_DONE = 2;
    localparam int EV_ERR  = 3;

    typedef struct {
        int kind;
        int file;
        int rw;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst, start, abort;
    logic [1:0] stage_sel;
    logic       busy, done, err;

    io_sequencer_if bus();

    io_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stage_sel (stage_sel),
        .abort     (abort),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Reference stage table indexed by stage_sel 0..2
    int T_IN_LO[3]  = '{0, 129, 2402};
    int T_IN_HI[3]  = '{0, 160, 2405};
    int T_PAR_LO[3] = '{1, 161, 2406};
    int T_PPO[3]    = '{1, 32, 40};
    int T_N_OUT[3]  = '{32, 64, 1};
    int T_OUT_LO[3] = '{97, 2338, 2447};

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  io_min = 3, io_max = 3, calc_min = 5, calc_max = 5;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    function automatic void push_ev(input int kind, input int file, input int rw);
        ev_t e;
        e.kind = kind;
        e.file = file;
        e.rw   = rw;
        exp_q.push_back(e);
    endfunction

    // Whole-stage transfer plan straight from the table rules
    function automatic void build_stage(input int s);
        for (int f = T_IN_LO[s]; f <= T_IN_HI[s]; f++) push_ev(EV_IO, f, 0);
        for (int o = 0; o < T_N_OUT[s]; o++) begin
            for (int p = 0; p < T_PPO[s]; p++) push_ev(EV_IO, T_PAR_LO[s] + o * T_PPO[s] + p, 0);
            push_ev(EV_CALC, 0, 0);
            push_ev(EV_IO, T_OUT_LO[s] + o, 1);
        end
        push_ev(EV_DONE, 0, 0);
    endfunction

    task automatic pop_check(input int kind, input int file, input int rw);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got kind %0d file %0d rw %0d, expected none at %0t",
                     kind, file, rw, $time);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", kind, e.kind);
            if (kind == EV_IO && e.kind == EV_IO) begin
                chk("io_file", file, e.file);
                chk("io_rw", rw, e.rw);
            end
        end
    endtask

    // IO stage model
    initial begin
        int icnt, itgt;
        icnt = 0;
        itgt = 1;
        bus.io_done = 1'b0;
        forever begin
            @(negedge clk);
            bus.io_done = 1'b0;
            if (bus.io_req && !rst) begin
                if (icnt == 0) itgt = int'($urandom_range(io_max, io_min));
                icnt++;
                if (icnt >= itgt) begin
                    bus.io_done = 1'b1;
                    icnt = 0;
                end
            end else begin
                icnt = 0;
            end
        end
    end

    // Compute engine model
    initial begin
        int  ccnt, ctgt;
        logic cpend;
        ccnt = 0;
        ctgt = 1;
        cpend = 1'b0;
        bus.calc_done = 1'b0;
        forever begin
            @(negedge clk);
            bus.calc_done = 1'b0;
            if (rst) begin
                cpend = 1'b0;
            end else begin
                if (bus.calc_start) begin
                    cpend = 1'b1;
                    ccnt  = 0;
                    ctgt  = int'($urandom_range(calc_max, calc_min));
                end
                if (cpend) begin
                    ccnt++;
                    if (ccnt >= ctgt) begin
                        bus.calc_done = 1'b1;
                        cpend = 1'b0;
                    end
                end
            end
        end
    end

    // Monitor: samples just after each rising edge
    initial begin
        logic        prev_req, prev_rw;
        logic [15:0] prev_file;
        prev_req  = 1'b0;
        prev_rw   = 1'b0;
        prev_file = '0;
        forever begin
            @(posedge clk);
            #2;
            if (rst) begin
                prev_req = 1'b0;
                continue;
            end
            if (prev_req && bus.io_done) begin
                chk("req_gap_after_done", 32'(bus.io_req), 32'd0);
            end else if (prev_req && bus.io_req) begin
                chk("io_file_stable", 32'(bus.io_file), 32'(prev_file));
                chk("io_rw_stable", 32'(bus.io_rw), 32'(prev_rw));
            end
            if (bus.io_req && !prev_req) pop_check(EV_IO, int'(bus.io_file), int'(bus.io_rw));
            if (bus.calc_start) pop_check(EV_CALC, 0, 0);
            if (done) pop_check(EV_DONE, 0, 0);
            if (err) pop_check(EV_ERR, 0, 0);
            prev_req  = bus.io_req;
            prev_file = bus.io_file;
            prev_rw   = bus.io_rw;
        end
    end

    task automatic issue_start(input int sel);
        @(negedge clk);
        stage_sel = 2'(sel);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_empty(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL timeout: %0d events still pending, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic idle_check(input string name);
        repeat (2) @(negedge clk);
        chk(name, 32'(busy), 32'd0);
    endtask

    task automatic check_all_zero();
        chk("rst_io_req", 32'(bus.io_req), 32'd0);
        chk("rst_io_file", 32'(bus.io_file), 32'd0);
        chk("rst_io_rw", 32'(bus.io_rw), 32'd0);
        chk("rst_calc_start", 32'(bus.calc_start), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
    endtask

    initial begin
        int n, hits;
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        stage_sel = 2'd0;
        repeat (3) @(negedge clk);
        check_all_zero();
        rst = 1'b0;

        // conv1 with fixed 3-cycle IO and 5-cycle compute latency
        build_stage(0);
        issue_start(0);
        wait_empty(20000);
        idle_check("busy_after_conv1");

        // fc with randomized latencies
        io_min = 1; io_max = 4; calc_min = 1; calc_max = 6;
        build_stage(2);
        issue_start(2);
        wait_empty(20000);
        idle_check("busy_after_fc");

        // conv2 full run, includes o=63 params 2177..2208 then write 2401
        io_min = 1; io_max = 3; calc_min = 1; calc_max = 4;
        build_stage(1);
        issue_start(1);
        wait_empty(60000);
        idle_check("busy_after_conv2");

        // invalid stage_sel
        push_ev(EV_ERR, 0, 0);
        issue_start(3);
        wait_empty(20);
        hits = 0;
        repeat (5) begin
            @(negedge clk);
            if (busy) hits++;
        end
        chk("busy_after_err", hits, 0);

        // second start during a conv1 run must not disturb it
        build_stage(0);
        issue_start(0);
        repeat (40) @(negedge clk);
        stage_sel = 2'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_empty(20000);
        idle_check("busy_after_restart_ignored");

        // abort coincident with io_done on parameter file 5 (conv1 LOAD_PAR, o=4)
        build_stage(0);
        issue_start(0);
        n = 0;
        hits = 0;
        while (n < 5000 && hits == 0) begin
            @(negedge clk);
            #1;
            n++;
            if (bus.io_done && bus.io_req && bus.io_file == 16'd5 && !bus.io_rw) hits = 1;
        end
        chk("abort_window_found", hits, 1);
        abort = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        #2;
        chk("abort_io_req", 32'(bus.io_req), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        @(negedge clk);
        abort = 1'b0;
        hits = 0;
        repeat (10) begin
            @(negedge clk);
            if (done || busy) hits++;
        end
        chk("abort_no_done", hits, 0);

        // asynchronous reset while a STORE request is outstanding
        build_stage(0);
        issue_start(0);
        n = 0;
        hits = 0;
        while (n < 5000 && hits == 0) begin
            @(negedge clk);
            #1;
            n++;
            if (bus.io_req && bus.io_rw) hits = 1;
        end
        chk("store_window_found", hits, 1);
        #1;
        rst = 1'b1;
        #1;
        check_all_zero();
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        build_stage(0);
        issue_start(0);
        wait_empty(20000);
        idle_check("busy_after_rst_rerun");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
